// File: rtl/mult_pkg.sv
// Purpose: shared definitions for the multiplier arbiter and the multiplier control/datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_pkg;

    // Default operand width; product is twice this.
    localparam int MULT_WIDTH = 8;

    // Arbiter FSM encoding, shared with the multiplier control unit.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Purpose: round-robin pick of the first set request bit at or above ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; result is only consumed when the arbiter is idle.
// Ports: req[N] requests, ptr index of highest-priority requester;
//        gnt one-hot winner, index binary winner, any = at least one request set.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] index,
    output logic          any
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt   = '0;
        index = '0;
        any   = 1'b0;
        idx   = '0;
        // Walk N positions starting at ptr; the first hit wins.
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                any      = 1'b1;
                index    = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Purpose: shares one start/done multiplier among N requesters with round-robin grant.
// Latency: req sampled at edge k -> mul_start from k+1; done seen at edge m -> ack at earliest m+2.
// Backpressure: requesters hold req until their one-cycle ack; only sampled while idle.
// Ports: req/opa/opb per requester in; ack/res/err result out; grant/busy status;
//        mul_start/mul_a/mul_b to multiplier, mul_done/mul_p from multiplier.
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = MULT_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] opa,
    input  logic [N*WIDTH-1:0] opb,
    output logic [N-1:0]       ack,
    output logic [2*WIDTH-1:0] res,
    output logic               err,
    output logic [N-1:0]       grant,
    output logic               busy,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_p
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e             state_q,     state_d;
    logic [IW-1:0]      ptr_q,       ptr_d;
    logic [IW-1:0]      gidx_q,      gidx_d;
    logic [N-1:0]       grant_q,     grant_d;
    logic [N-1:0]       ack_q,       ack_d;
    logic [WIDTH-1:0]   mul_a_q,     mul_a_d;
    logic [WIDTH-1:0]   mul_b_q,     mul_b_d;
    logic               mul_start_q, mul_start_d;
    logic [2*WIDTH-1:0] res_q,       res_d;
    logic               err_q,       err_d;
    logic [CW-1:0]      cnt_q,       cnt_d;

    logic [N-1:0]       pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    rr_pick #(.N(N), .IW(IW)) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .index (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        ack_d       = '0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_start_d = mul_start_q;
        res_d       = res_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d     = pick_gnt;
                    gidx_d      = pick_idx;
                    mul_a_d     = opa[pick_idx*WIDTH +: WIDTH];
                    mul_b_d     = opb[pick_idx*WIDTH +: WIDTH];
                    cnt_d       = '0;
                    mul_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + CW'(1);
                // cnt_q==0 means start has not yet been seen at an edge, so any
                // done seen now is left over and must be ignored.
                if (mul_done && (cnt_q != '0)) begin
                    res_d       = mul_p;
                    err_d       = 1'b0;
                    mul_start_d = 1'b0;
                    state_d     = ST_RELEASE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_d       = '0;
                    err_d       = 1'b1;
                    mul_start_d = 1'b0;
                    state_d     = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Wait for the multiplier to drop done so the next grant starts clean.
                if (!mul_done) begin
                    ack_d   = grant_q;
                    ptr_d   = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + IW'(1);
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            res_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_start_q <= mul_start_d;
            res_q       <= res_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ack       = ack_q;
    assign res       = res_q;
    assign err       = err_q;
    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Purpose: randomized scoreboard bench for mult_share_arbiter with a behavioural multiplier.
// Latency: n/a.
// Backpressure: requesters hold req until ack, then re-request or drop.
module tb_mult_share_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 64;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req;
    logic [N*W-1:0]   opa, opb;
    logic [N-1:0]     ack, grant;
    logic [2*W-1:0]   res, mul_p;
    logic             err, busy, mul_start, mul_done;
    logic [W-1:0]     mul_a, mul_b;

    always #5 clk = ~clk;

    mult_share_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .opa(opa), .opb(opb),
        .ack(ack), .res(res), .err(err), .grant(grant), .busy(busy),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_p(mul_p)
    );

    // Behavioural multiplier: random latency, done held until start drops; hang = never done.
    bit hang = 1'b0;
    int mlat, mcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_done <= 1'b0; mul_p <= '0; mcnt <= 0; mlat <= 2;
        end else if (!mul_start) begin
            mul_done <= 1'b0; mcnt <= 0;
        end else if (!mul_done && !hang) begin
            if (mcnt >= mlat) begin
                mul_done <= 1'b1;
                mul_p    <= 16'(mul_a) * 16'(mul_b);
                mlat     <= $urandom_range(0, 6);
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    typedef struct {
        int           idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] res;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    exp_t expg_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: checks grant onset against the grant queue and every ack against the result queue.
    bit   mon_en = 1'b1;
    logic [N-1:0] prev_grant = '0;
    int   cyc = 0;
    int   gstart = 0;
    exp_t m;
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (mon_en && rst_n) begin
            if (grant != '0 && prev_grant == '0) begin
                if (expg_q.size() == 0) begin
                    chk("grant_unexpected", 32'(grant), 0);
                end else begin
                    m = expg_q.pop_front();
                    chk("grant", 32'(grant), 32'(1) << m.idx);
                    chk("mul_a", 32'(mul_a), 32'(m.a));
                    chk("mul_b", 32'(mul_b), 32'(m.b));
                    gstart = cyc;
                end
            end
            if (ack != '0) begin
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", 32'(ack), 0);
                end else begin
                    m = exp_q.pop_front();
                    chk("ack", 32'(ack), 32'(1) << m.idx);
                    chk("res", 32'(res), 32'(m.res));
                    chk("err", 32'(err), 32'(m.err));
                    chk("grant_clear_at_ack", 32'(grant), 0);
                    chk("busy_at_ack", 32'(busy), 0);
                    if (m.err)
                        chk("timeout_latency_in_range",
                            32'((cyc - gstart >= T) && (cyc - gstart <= T + 3)), 1);
                end
            end
        end
        prev_grant = grant;
    end

    // Per-requester job lists and the reference round-robin pointer.
    logic [W-1:0] ja[N][16];
    logic [W-1:0] jb[N][16];
    int nj[N];
    int model_ptr = 0;

    task automatic clear_nj();
        for (int i = 0; i < N; i++) nj[i] = 0;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < nj[i]; k++) begin
                ja[i][k] = 8'($urandom);
                jb[i][k] = 8'($urandom);
            end
    endtask

    // Reference model: served set = requesters with jobs left; next = first from pointer upward.
    task automatic run_phase(input bit to);
        int rem[N];
        int k[N];
        int p, g, left, total, c;
        exp_t e;
        p = model_ptr;
        left = 0;
        for (int i = 0; i < N; i++) begin rem[i] = nj[i]; k[i] = 0; left += nj[i]; end
        total = left;
        while (left > 0) begin
            g = -1;
            for (int s = 0; s < N; s++) begin
                c = (p + s) % N;
                if (g < 0 && rem[c] > 0) g = c;
            end
            e.idx = g;
            e.a   = ja[g][nj[g] - rem[g]];
            e.b   = jb[g][nj[g] - rem[g]];
            e.err = to;
            e.res = to ? 16'd0 : 16'(e.a) * 16'(e.b);
            exp_q.push_back(e);
            expg_q.push_back(e);
            rem[g]--;
            left--;
            p = (g + 1) % N;
        end
        model_ptr = p;

        for (int i = 0; i < N; i++)
            if (nj[i] > 0) begin
                opa[i*W +: W] = ja[i][0];
                opb[i*W +: W] = jb[i][0];
                req[i] = 1'b1;
            end
        left = total;
        c = 0;
        while (left > 0 && c < 4000) begin
            @(posedge clk);
            #1;
            c++;
            for (int i = 0; i < N; i++)
                if (ack[i]) begin
                    k[i]++;
                    left--;
                    if (k[i] < nj[i]) begin
                        opa[i*W +: W] = ja[i][k[i]];
                        opb[i*W +: W] = jb[i][k[i]];
                    end else begin
                        req[i] = 1'b0;
                    end
                end
        end
        if (left > 0) begin
            chk("phase_acks_outstanding", 32'(left), 0);
            req = '0;
        end
    endtask

    task automatic settle();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || expg_q.size() != 0 || busy) && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 200) chk("settle_timeout", 32'(exp_q.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ack"},       32'(ack), 0);
        chk({tag, "_grant"},     32'(grant), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_mul_start"}, 32'(mul_start), 0);
        chk({tag, "_res"},       32'(res), 0);
        chk({tag, "_err"},       32'(err), 0);
        chk({tag, "_mul_a"},     32'(mul_a), 0);
        chk({tag, "_mul_b"},     32'(mul_b), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int c;
        logic [W-1:0] a, b;
        req = '0; opa = '0; opb = '0;
        #1 rst_n = 1'b0;
        #3;
        reset_checks("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single request with known operands.
        clear_nj(); nj[0] = 1; ja[0][0] = 8'd13; jb[0][0] = 8'd11;
        run_phase(1'b0); settle();

        // All four requesting with several jobs each: strict rotation.
        clear_nj(); for (int i = 0; i < N; i++) nj[i] = 2;
        fill_rand(); run_phase(1'b0); settle();

        // Two requesters continuously: alternation.
        clear_nj(); nj[0] = 4; nj[2] = 4;
        fill_rand(); run_phase(1'b0); settle();

        // Random request mixes.
        for (int r = 0; r < 6; r++) begin
            clear_nj();
            for (int i = 0; i < N; i++) nj[i] = $urandom_range(0, 3);
            fill_rand(); run_phase(1'b0); settle();
        end

        // Withdrawal: req and operands change after grant; the latched operands win.
        a = 8'($urandom_range(1, 255)); b = 8'($urandom_range(1, 255));
        e.idx = 1; e.a = a; e.b = b; e.err = 1'b0; e.res = 16'(a) * 16'(b);
        exp_q.push_back(e); expg_q.push_back(e);
        model_ptr = 2;
        opa[W +: W] = a; opb[W +: W] = b; req[1] = 1'b1;
        c = 0;
        while (!grant[1] && c < 50) begin @(posedge clk); #1; c++; end
        chk("withdraw_grant_seen", 32'(grant[1]), 1);
        @(posedge clk); #1;
        req[1] = 1'b0; opa[W +: W] = ~a; opb[W +: W] = ~b;
        settle();

        // Timeout: multiplier never answers, then a normal transaction clears err.
        hang = 1'b1;
        clear_nj(); nj[3] = 1; fill_rand(); run_phase(1'b1); settle();
        hang = 1'b0;
        clear_nj(); nj[3] = 1; fill_rand(); run_phase(1'b0); settle();

        // Reset mid-transaction: leave the pointer non-zero first.
        clear_nj(); nj[2] = 1;
        ja[2][0] = 8'($urandom_range(1, 255)); jb[2][0] = 8'($urandom_range(1, 255));
        run_phase(1'b0); settle();
        mon_en = 1'b0;
        opa[W +: W] = 8'd7; opb[W +: W] = 8'd9; req = 4'b0010;
        c = 0;
        while (!mul_start && c < 50) begin @(posedge clk); #1; c++; end
        chk("pre_reset_mul_start", 32'(mul_start), 1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        reset_checks("midreset");
        req = '0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_ptr = 0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        clear_nj(); nj[1] = 1; nj[2] = 1; nj[3] = 1;
        fill_rand(); run_phase(1'b0); settle();

        chk("results_left", 32'(exp_q.size()), 0);
        chk("grants_left", 32'(expg_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
